// File: rtl/never_map_unit.sv
// never_map_unit: nibble-remap functional unit with parametrised LUTs, an iterative
// multi-cycle map engine, compare/select on a selection mask, and valid/ready handshakes.
`default_nettype none

module never_map_unit #(
  parameter int DATA_W    = 32,
  parameter int NUM_LUTS  = 4,
  parameter int MAP_LANES = 2,
  localparam int NIB      = DATA_W / 4,
  localparam int ITER     = NIB / MAP_LANES,
  localparam int SEL_W    = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [SEL_W-1:0]  in_lut_sel,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_res,
  output logic [1:0]        out_op,
  output logic [NIB-1:0]    sel_state
);

  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [SEL_W:0]   LUT_LIMIT = NUM_LUTS[SEL_W:0];
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

  localparam logic [1:0] OP_MAP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_CMP  = 2'b10;
  localparam logic [1:0] OP_SEL  = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'd0, MAP = 2'd1, RESULT = 2'd2} state_t;

  state_t            state, state_nx;
  logic [3:0]        lut [NUM_LUTS][16];
  logic [SEL_W-1:0]  map_idx;
  logic              map_idx_ok;
  logic [DATA_W-1:0] map_a;
  logic [CNT_W-1:0]  iter;

  logic              accept;
  logic              sel_ok;
  logic [63:0]       load_word;
  logic [NIB-1:0]    cmp_mask;
  logic [DATA_W-1:0] sel_res;
  logic [3:0]        lane_val [MAP_LANES];

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == RESULT);
  assign accept    = in_valid & in_ready;
  assign sel_ok    = ({1'b0, in_lut_sel} < LUT_LIMIT);
  assign load_word = {in_a[31:0], in_b[31:0]};

  always_comb begin
    cmp_mask = '0;
    sel_res  = '0;
    for (int k = 0; k < NIB; k++) begin
      cmp_mask[k]       = (in_a[4*k +: 4] == in_b[3:0]);
      sel_res[4*k +: 4] = sel_state[k] ? in_a[4*k +: 4] : in_b[4*k +: 4];
    end
  end

  // Lanes of the current iteration; an out-of-range table index maps to zero.
  always_comb begin
    for (int l = 0; l < MAP_LANES; l++) begin
      lane_val[l] = 4'h0;
      if (map_idx_ok)
        lane_val[l] = lut[map_idx][map_a[4*(int'(iter)*MAP_LANES + l) +: 4]];
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          case (in_op)
            OP_MAP:          state_nx = MAP;
            OP_CMP, OP_SEL:  state_nx = RESULT;
            default:         state_nx = IDLE;
          endcase
        end
      end
      MAP:     if (iter == LAST_ITER) state_nx = RESULT;
      RESULT:  if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      out_res    <= '0;
      out_op     <= '0;
      sel_state  <= '0;
      map_idx    <= '0;
      map_idx_ok <= 1'b0;
      map_a      <= '0;
      iter       <= '0;
      for (int n = 0; n < NUM_LUTS; n++)
        for (int i = 0; i < 16; i++)
          lut[n][i] <= 4'h0;
    end else begin
      state <= state_nx;
      if (accept) begin
        case (in_op)
          OP_LOAD: begin
            if (sel_ok)
              for (int i = 0; i < 16; i++)
                lut[in_lut_sel][i] <= load_word[63-4*i -: 4];
          end
          OP_MAP: begin
            map_idx    <= in_lut_sel;
            map_idx_ok <= sel_ok;
            map_a      <= in_a;
            iter       <= '0;
            out_res    <= '0;
            out_op     <= OP_MAP;
          end
          OP_CMP: begin
            sel_state <= cmp_mask;
            out_res   <= {{(DATA_W-NIB){1'b0}}, cmp_mask};
            out_op    <= OP_CMP;
          end
          default: begin
            out_res <= sel_res;
            out_op  <= OP_SEL;
          end
        endcase
      end
      if (state == MAP) begin
        iter <= iter + 1'b1;
        for (int l = 0; l < MAP_LANES; l++)
          out_res[4*(int'(iter)*MAP_LANES + l) +: 4] <= lane_val[l];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_never_map_unit.sv
// Directed self-checking bench: a default unit and a NUM_LUTS=3 unit driven in lockstep.
`default_nettype none

module tb_never_map_unit;

  logic        clk = 1'b0;
  logic        reset, in_valid, out_ready;
  logic [1:0]  in_op, in_lut_sel;
  logic [31:0] in_a, in_b;

  logic        in_ready, out_valid, in_ready3, out_valid3;
  logic [31:0] out_res, out_res3;
  logic [1:0]  out_op, out_op3;
  logic [7:0]  sel_state, sel_state3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  never_map_unit #(.DATA_W(32), .NUM_LUTS(4), .MAP_LANES(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_lut_sel(in_lut_sel), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_op(out_op), .sel_state(sel_state)
  );

  never_map_unit #(.DATA_W(32), .NUM_LUTS(3), .MAP_LANES(2)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready3),
    .in_op(in_op), .in_lut_sel(in_lut_sel), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid3), .out_ready(out_ready), .out_res(out_res3),
    .out_op(out_op3), .sel_state(sel_state3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] sel,
                       input logic [31:0] a, input logic [31:0] b);
    in_valid   = 1'b1;
    in_op      = op;
    in_lut_sel = sel;
    in_a       = a;
    in_b       = b;
    tick();
    in_valid   = 1'b0;
  endtask

  // Called right after the accept edge: result must appear exactly 4 edges later.
  task automatic map_check(input string tag, input logic [31:0] exp, input logic [31:0] exp3);
    for (int j = 0; j < 4; j++) begin
      chk({tag, "_busy_valid"}, out_valid, 1'b0);
      chk({tag, "_busy_ready"}, in_ready, 1'b0);
      tick();
    end
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_res"}, out_res, exp);
    chk({tag, "_op"}, out_op, 2'b00);
    chk({tag, "_valid3"}, out_valid3, 1'b1);
    chk({tag, "_res3"}, out_res3, exp3);
  endtask

  task automatic retire(input string tag);
    tick();
    chk({tag, "_retire_valid"}, out_valid, 1'b0);
    chk({tag, "_retire_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_op = 2'b00; in_lut_sel = 2'd0; in_a = '0; in_b = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_sel", sel_state, 8'h00);
    chk("rst_res", out_res, 32'h0);
    chk("rst_op", out_op, 2'b00);

    // Map through an all-zero table.
    issue(2'b00, 2'd0, 32'h12345678, 32'h0);
    map_check("map_lut0", 32'h0000_0000, 32'h0000_0000);
    retire("map_lut0");

    // Load LUT1 with entry i = 15-i, then map on the very next cycle.
    issue(2'b01, 2'd1, 32'hFEDCBA98, 32'h76543210);
    chk("load_ready", in_ready, 1'b1);
    chk("load_novalid", out_valid, 1'b0);
    issue(2'b00, 2'd1, 32'h12345678, 32'h0);
    map_check("map_lut1", 32'hEDCBA987, 32'hEDCBA987);
    retire("map_lut1");

    // Compare then select against the latched mask.
    issue(2'b10, 2'd0, 32'h50505055, 32'h00000005);
    chk("cmp_valid", out_valid, 1'b1);
    chk("cmp_res", out_res, 32'h000000AB);
    chk("cmp_sel", sel_state, 8'hAB);
    chk("cmp_op", out_op, 2'b10);
    retire("cmp");
    issue(2'b11, 2'd0, 32'h11111111, 32'h22222222);
    chk("sel_valid", out_valid, 1'b1);
    chk("sel_res", out_res, 32'h12121211);
    chk("sel_op", out_op, 2'b11);
    chk("sel_res3", out_res3, 32'h12121211);
    retire("sel");

    // Backpressure: result held for 5 cycles while a competing op is offered.
    out_ready = 1'b0;
    issue(2'b00, 2'd1, 32'h12345678, 32'h0);
    map_check("bp_map", 32'hEDCBA987, 32'hEDCBA987);
    in_valid = 1'b1; in_op = 2'b10; in_a = 32'h0; in_b = 32'h0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_res", out_res, 32'hEDCBA987);
      chk("bp_op", out_op, 2'b00);
      chk("bp_ready", in_ready, 1'b0);
      chk("bp_sel", sel_state, 8'hAB);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", out_valid, 1'b0);
    chk("bp_release_ready", in_ready, 1'b1);
    issue(2'b10, 2'd0, 32'h00000000, 32'h00000000);
    chk("bp_next_valid", out_valid, 1'b1);
    chk("bp_next_res", out_res, 32'h000000FF);
    chk("bp_next_sel", sel_state, 8'hFF);
    retire("bp_next");

    // Table index 3: valid on the 4-LUT unit, dropped on the 3-LUT unit.
    issue(2'b01, 2'd3, 32'h01234567, 32'h89ABCDEF);
    issue(2'b00, 2'd3, 32'h12345678, 32'h0);
    map_check("map_sel3", 32'h12345678, 32'h00000000);
    retire("map_sel3");
    issue(2'b00, 2'd1, 32'h12345678, 32'h0);
    map_check("map_lut1_kept", 32'hEDCBA987, 32'hEDCBA987);
    retire("map_lut1_kept");

    // Reset during MAP iteration 2.
    issue(2'b00, 2'd1, 32'h12345678, 32'h0);
    tick(); tick();
    chk("pre_rst_busy", out_valid, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_ready", in_ready, 1'b1);
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_sel", sel_state, 8'h00);
    chk("midrst_res", out_res, 32'h0);
    tick();
    chk("midrst_stay_valid", out_valid, 1'b0);
    issue(2'b00, 2'd1, 32'h12345678, 32'h0);
    map_check("midrst_lut_clear", 32'h00000000, 32'h00000000);
    retire("midrst_lut_clear");
    issue(2'b01, 2'd2, 32'h01234567, 32'h89ABCDEF);
    issue(2'b00, 2'd2, 32'hCAFEF00D, 32'h0);
    map_check("identity", 32'hCAFEF00D, 32'hCAFEF00D);
    retire("identity");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/never_map_unit.md
Name: never_map_unit

Overview:
- Next-generation nibble-remap functional unit for the NEVE instruction group.
- Generalises the fixed single-cycle map/select/compare unit:
  - parametrised data width and LUT count
  - parametrised map lanes per cycle, with an iterative multi-cycle map engine
  - valid/ready issue and result handshakes with output backpressure
  - compare results returned on the result bus
- Sits in the backend beside the other FUBs. The issue stage feeds it decoded ops and operands; the writeback arbiter consumes its results.

Parameters:
- DATA_W, 32: operand/result width; multiple of 4, >= 32; NIB = DATA_W/4 nibbles.
- NUM_LUTS, 4: number of 16x4-bit lookup tables; >= 2.
- MAP_LANES, 2: nibbles mapped per cycle; must divide NIB; ITER = NIB/MAP_LANES.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  op offered
- in_ready  out  1  unit can accept op
- in_op  in  2  00 map, 01 load LUT, 10 compare, 11 select
- in_lut_sel  in  clog2(NUM_LUTS)  LUT index for map/load
- in_a  in  DATA_W  operand a
- in_b  in  DATA_W  operand b
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_res  out  DATA_W  result word
- out_op  out  2  op code of the result held
- sel_state  out  NIB  current selection mask

Behaviour:
- Clock and reset:
  - One clock (clk); reset is synchronous and active-high.
  - Reset effects: state IDLE; in_ready=1; out_valid=0; out_res=0; out_op=0; sel_state=0; all LUT entries=0.
  - Reset mid-operation discards any partial map or held result.
- Accept and FSM:
  - Accept = in_valid & in_ready at a rising edge t.
  - in_ready=1 only in IDLE.
  - FSM states: IDLE, MAP, RESULT.
- Load (01):
  - Stays in IDLE.
  - At edge t, LUT[in_lut_sel] entry i = {in_a[31:0], in_b[31:0]}[63-4i -: 4], for i = 0..15 (entry 0 = in_a[31:28]).
  - Produces no result.
  - in_lut_sel >= NUM_LUTS: load dropped.
  - A map accepted at t+1 sees the new table.
- Map (00):
  - IDLE->MAP; lut index and in_a are latched.
  - Each MAP cycle j (0..ITER-1) produces nibbles k = j*MAP_LANES .. j*MAP_LANES+MAP_LANES-1 as res[k] = LUT[idx][a[k]].
  - Nibbles are produced low nibbles first, into an accumulator.
  - After the last iteration -> RESULT: out_valid rises at edge t+ITER, out_op=00.
  - Invalid idx: result 0, same latency.
- Compare (10):
  - mask[k] = (a nibble k == in_b[3:0]).
  - At edge t: sel_state<=mask and out_res<={zero-extend mask}; -> RESULT; out_valid at t+1.
- Select (11):
  - res nibble k = sel_state[k] ? a nibble k : b nibble k, using sel_state as of edge t.
  - -> RESULT; out_valid at t+1.
- RESULT:
  - out_res and out_op are held stable while out_ready=0.
  - out_valid & out_ready at an edge: out_valid<=0 and -> IDLE; in_ready high the following cycle.
- No hazards are possible: only one op is in flight, and loads only occur in IDLE.
- Arithmetic: none. Widths are exact; unused upper bits of out_res for compare are 0.
- in_op/in_lut_sel/in_a/in_b are ignored when not accepted.

Test Plan:
- Reset then idle: out_valid=0, in_ready=1, sel_state=0; map a=0x12345678 on LUT0 -> 0x00000000 after ITER=4 cycles.
- Load LUT1 with a=0xFEDCBA98, b=0x76543210 (entry i = 15-i); map a=0x12345678 -> out_res=0xEDCBA987, out_valid exactly 4 edges after accept; a map issued the cycle right after the load sees the new table.
- Compare a=0x50505055, b=0x5 -> out_res=0x000000AB, sel_state=0xAB at t+1; then select a=0x11111111, b=0x22222222 -> 0x12121211.
- Backpressure: hold out_ready=0 for 5 cycles during a map result -> out_res/out_op stable, in_ready=0, in_valid ignored; release -> IDLE next cycle, new op accepted.
- Invalid in_lut_sel (NUM_LUTS=3, sel=3): load dropped (LUTs unchanged); map -> 0.
- Reset asserted at MAP iteration 2 -> next cycle IDLE, out_valid=0, LUTs and sel_state cleared; following identity-load+map returns the input word.
